// File: rtl/mux_arb_defs.sv
// Shared arbiter definitions: FSM state encodings reused by the mux/arbiter family.
package mux_arb_defs;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mux_2_1_w.sv
// WIDTH-bit 2:1 multiplexer, purely combinational: y = sel ? b : a.
module mux_2_1_w #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/mux_2_1_rr_arbiter.sv
// Two-requester round-robin arbiter feeding a registered 2:1 mux; one grant in flight,
// output held under backpressure, one-cycle ack pulse after each downstream handshake.
module mux_2_1_rr_arbiter
  import mux_arb_defs::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic [WIDTH-1:0] data_a,
  output logic             ack_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_b,
  output logic             ack_b,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             sel,
  output logic             busy
);

  arb_state_t       state, state_nxt;
  logic             pri, pri_nxt;
  logic             sel_nxt;
  logic             out_valid_nxt;
  logic             ack_a_nxt, ack_b_nxt;
  logic             load;
  logic             pick_b;
  logic [WIDTH-1:0] mux_y;

  // B wins when it is the only requester, or on a tie when priority favours it.
  assign pick_b = req_b && (!req_a || pri);

  mux_2_1_w #(.WIDTH(WIDTH)) u_mux (
    .a   (data_a),
    .b   (data_b),
    .sel (pick_b),
    .y   (mux_y)
  );

  always_comb begin
    state_nxt     = state;
    pri_nxt       = pri;
    sel_nxt       = sel;
    out_valid_nxt = out_valid;
    ack_a_nxt     = 1'b0;
    ack_b_nxt     = 1'b0;
    load          = 1'b0;
    case (state)
      IDLE: begin
        out_valid_nxt = 1'b0;
        if (req_a || req_b) begin
          load          = 1'b1;
          sel_nxt       = pick_b;
          out_valid_nxt = 1'b1;
          state_nxt     = pick_b ? GRANT_B : GRANT_A;
        end
      end
      GRANT_A: begin
        if (out_ready) begin
          ack_a_nxt     = 1'b1;
          out_valid_nxt = 1'b0;
          pri_nxt       = 1'b1;
          state_nxt     = IDLE;
        end
      end
      GRANT_B: begin
        if (out_ready) begin
          ack_b_nxt     = 1'b1;
          out_valid_nxt = 1'b0;
          pri_nxt       = 1'b0;
          state_nxt     = IDLE;
        end
      end
      default: begin
        out_valid_nxt = 1'b0;
        state_nxt     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pri       <= 1'b0;
      sel       <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      ack_a     <= 1'b0;
      ack_b     <= 1'b0;
    end else begin
      state     <= state_nxt;
      pri       <= pri_nxt;
      sel       <= sel_nxt;
      out_valid <= out_valid_nxt;
      ack_a     <= ack_a_nxt;
      ack_b     <= ack_b_nxt;
      if (load) out_data <= mux_y;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: doc/mux_2_1_rr_arbiter.md
MUX_2_1_RR_ARBITER -- requirements
Module: mux_2_1_rr_arbiter

Interface
REQ-001 Parameter: WIDTH, default 8, data width of both requester ports and the output port.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 req_a  input  1  requester A wants one transfer; held high until ack_a.
REQ-005 data_a  input  WIDTH  requester A payload; stable while req_a is high.
REQ-006 ack_a  output  1  one-cycle pulse: A's transfer accepted downstream.
REQ-007 req_b  input  1  requester B request; same rules as req_a.
REQ-008 data_b  input  WIDTH  requester B payload; same rules as data_a.
REQ-009 ack_b  output  1  one-cycle pulse: B's transfer accepted downstream.
REQ-010 out_valid  output  1  out_data holds a granted transfer.
REQ-011 out_data  output  WIDTH  registered payload of the granted requester.
REQ-012 out_ready  input  1  downstream accepts out_data when high together with out_valid.
REQ-013 sel  output  1  current mux select: 0 = A, 1 = B.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 The FSM SHALL have three states: IDLE, GRANT_A and GRANT_B.
REQ-016 A priority bit pri (0 = A first, 1 = B first) SHALL resolve simultaneous requests in IDLE.
REQ-017 IDLE with only req_a high, or both high and pri=0: sel<=0, out_data<=data_a, out_valid<=1, next state GRANT_A.
REQ-018 IDLE with only req_b high, or both high and pri=1: sel<=1, out_data<=data_b, out_valid<=1, next state GRANT_B.
REQ-019 IDLE with no request: all outputs hold, out_valid=0.
REQ-020 Latency: a request sampled high in IDLE at edge N SHALL produce out_valid=1 after edge N.
REQ-021 In GRANT_x, out_valid, out_data and sel SHALL stay constant until a cycle with out_valid && out_ready.
REQ-022 On the handshake edge, the FSM SHALL:
  - pulse ack_x for exactly one cycle;
  - clear out_valid;
  - set pri to favour the other requester;
  - return to IDLE.
REQ-023 Throughput is at most one transfer per two cycles, with one mandatory IDLE bubble between grants.
REQ-024 req_x still high in the cycle after ack_x SHALL be treated as a new request, arbitrated by the updated pri.
REQ-025 A request dropped by the requester while in GRANT_x SHALL NOT abort the transfer; the grant completes on out_ready.
REQ-026 ack_a and ack_b SHALL never be high in the same cycle.
REQ-027 The non-granted requester SHALL be held off (no ack, no data sampled) until the next IDLE arbitration.
REQ-028 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-029 rst high SHALL immediately force:
  - state=IDLE, pri=0, sel=0;
  - out_valid=0, out_data=0;
  - ack_a=0, ack_b=0, busy=0.
REQ-030 Reset asserted mid-grant SHALL drop the transfer with no ack issued; the requester re-arbitrates after release.
REQ-031 The first edge after rst deasserts SHALL perform a normal IDLE arbitration.

Structure
REQ-032 State encodings (IDLE=2'd0, GRANT_A=2'd1, GRANT_B=2'd2) SHALL live in a shared package/include, mux_arb_defs, for reuse by future arbiters.
REQ-033 The datapath SHALL be a sub-module mux_2_1_w, a WIDTH-bit 2:1 mux (sel ? b : a) whose output feeds the out_data register.
REQ-034 FSM, priority bit and output registers SHALL reside in mux_2_1_rr_arbiter.

Verification
REQ-035 Single requester: req_a=1, data_a=8'h5A, out_ready=1 -> out_valid next cycle with out_data=8'h5A, sel=0; ack_a pulses one cycle; back to IDLE.
REQ-036 Contention after reset: req_a=req_b=1, data_a=8'h11, data_b=8'h22, out_ready=1 held -> grant order A(8'h11), B(8'h22), A, B…; alternation persists with no starvation.
REQ-037 Backpressure: grant B with data_b=8'hC3 and out_ready=0 for 5 cycles -> out_valid, out_data=8'hC3 and sel=1 stable all 5 cycles; ack_b only on the cycle after out_ready rises.
REQ-038 Reset mid-grant: rst pulses while in GRANT_A with out_ready=0 -> out_valid=0, ack_a never pulses, pri=0; req_a re-granted first after release.
REQ-039 Request withdrawal: req_b drops one cycle after grant B -> transfer still completes on out_ready, ack_b pulses once, then IDLE.
REQ-040 Assertions across all tests:
  - ack_a and ack_b are never high together;
  - out_data never changes while out_valid && !out_ready;
  - busy equals (state != IDLE).
